// File: rtl/alu_sequencer.sv
// Instruction sequencer for an external ALU: a 4-deep instruction FIFO feeding
// a two-state IDLE/EXEC engine that holds ALU inputs stable and retires into acc.
module alu_sequencer #(
  parameter int MUL_CYC = 4,
  parameter int DIV_CYC = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [3:0]  in_op,
  input  logic [15:0] in_operand,
  output logic        in_ready,
  output logic [3:0]  alu_op_code,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic [31:0] alu_r,
  input  logic        alu_err,
  output logic [31:0] acc,
  output logic        done,
  output logic        busy,
  output logic        ovf_flag,
  output logic        dz_flag,
  input  logic        clr_flags,
  output logic [7:0]  op_count
);

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_MOD    = 4'd1;
  localparam logic [3:0] OP_DIV    = 4'd2;
  localparam logic [3:0] OP_RESET  = 4'd3;
  localparam logic [3:0] OP_MUL    = 4'd4;
  localparam logic [3:0] OP_SUB    = 4'd8;
  localparam logic [3:0] OP_NOOP   = 4'd13;
  localparam logic [3:0] OP_GROUND = 4'd14;
  localparam logic [3:0] OP_PRESET = 4'd15;

  typedef enum logic {S_IDLE, S_EXEC} state_t;

  state_t      state, state_next;
  logic [19:0] fifo_mem [4];
  logic [1:0]  wr_ptr, rd_ptr;
  logic [2:0]  fifo_cnt;
  logic [19:0] head;
  logic        push, pop, retire;
  logic [3:0]  cur_op;
  logic [15:0] cur_operand;
  logic [7:0]  cnt;
  logic        dz_pend;
  logic        ovf_set, dz_set;

  function automatic logic [7:0] exec_len_m1(input logic [3:0] op);
    case (op)
      OP_MUL:         return 8'(MUL_CYC - 1);
      OP_MOD, OP_DIV: return 8'(DIV_CYC - 1);
      default:        return 8'd0;
    endcase
  endfunction

  assign in_ready    = (fifo_cnt != 3'd4);
  assign push        = in_valid && in_ready;
  assign head        = fifo_mem[rd_ptr];
  assign alu_op_code = (state == S_EXEC) ? cur_op : OP_NOOP;
  assign alu_a       = cur_operand;
  assign alu_b       = acc[15:0];
  assign busy        = (state != S_IDLE) || (fifo_cnt != 3'd0);

  assign ovf_set = retire && alu_err && ((cur_op == OP_ADD) || (cur_op == OP_SUB));
  assign dz_set  = retire && dz_pend;

  // NOTE: the FIFO storage carries no reset; occupancy and pointers alone
  // decide validity, so the array can map onto plain register/RAM cells.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {in_op, in_operand};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      // Simultaneous push and pop leave occupancy unchanged.
      if (push && !pop)      fifo_cnt <= fifo_cnt + 3'd1;
      else if (pop && !push) fifo_cnt <= fifo_cnt - 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    retire     = 1'b0;
    case (state)
      S_IDLE: begin
        if (fifo_cnt != 3'd0) begin
          pop        = 1'b1;
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cnt == 8'd0) begin
          retire     = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_op      <= OP_NOOP;
      cur_operand <= '0;
      cnt         <= '0;
      dz_pend     <= 1'b0;
      acc         <= '0;
      done        <= 1'b0;
      op_count    <= '0;
      ovf_flag    <= 1'b0;
      dz_flag     <= 1'b0;
    end else begin
      done <= retire;
      if (pop) begin
        cur_op      <= head[19:16];
        cur_operand <= head[15:0];
        cnt         <= exec_len_m1(head[19:16]);
        // Divide-by-zero is judged on the divisor as it stands at pop time.
        dz_pend     <= ((head[19:16] == OP_MOD) || (head[19:16] == OP_DIV)) &&
                       (acc[15:0] == 16'd0);
      end else if ((state == S_EXEC) && (cnt != 8'd0)) begin
        cnt <= cnt - 8'd1;
      end
      if (retire) begin
        op_count <= op_count + 8'd1;
        case (cur_op)
          OP_NOOP:             acc <= acc;
          OP_RESET, OP_GROUND: acc <= '0;
          OP_PRESET:           acc <= '1;
          default:             acc <= alu_r;
        endcase
      end
      // A set event in the same cycle as clr_flags takes priority.
      ovf_flag <= ovf_set | (ovf_flag & ~clr_flags);
      dz_flag  <= dz_set  | (dz_flag  & ~clr_flags);
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU; inputs are driven
// and outputs sampled on the falling clock edge.
module tb_alu_sequencer;

  localparam int MUL_CYC = 4;
  localparam int DIV_CYC = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [3:0]  in_op = 4'd0;
  logic [15:0] in_operand = 16'd0;
  logic        in_ready;
  logic [3:0]  alu_op_code;
  logic [15:0] alu_a, alu_b;
  logic [31:0] alu_r;
  logic        alu_err;
  logic [31:0] acc;
  logic        done, busy, ovf_flag, dz_flag;
  logic        clr_flags = 1'b0;
  logic [7:0]  op_count;

  int n_vec  = 0;
  int n_miss = 0;

  alu_sequencer #(.MUL_CYC(MUL_CYC), .DIV_CYC(DIV_CYC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_op(in_op),
    .in_operand(in_operand), .in_ready(in_ready), .alu_op_code(alu_op_code),
    .alu_a(alu_a), .alu_b(alu_b), .alu_r(alu_r), .alu_err(alu_err),
    .acc(acc), .done(done), .busy(busy), .ovf_flag(ovf_flag),
    .dz_flag(dz_flag), .clr_flags(clr_flags), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Behavioural ALU; ops the sequencer must override return a junk pattern.
  logic [31:0] a32, b32;
  always_comb begin
    a32     = {16'h0, alu_a};
    b32     = {16'h0, alu_b};
    alu_r   = 32'hDEAD_BEEF;
    alu_err = 1'b0;
    case (alu_op_code)
      4'd0:  begin alu_r = a32 + b32; alu_err = alu_r[16]; end
      4'd1:  alu_r = (b32 == 32'd0) ? 32'hFFFF_FFFF : a32 % b32;
      4'd2:  alu_r = (b32 == 32'd0) ? 32'hFFFF_FFFF : a32 / b32;
      4'd4:  alu_r = a32 * b32;
      4'd5:  alu_r = a32 & b32;
      4'd6:  alu_r = a32 | b32;
      4'd7:  alu_r = ~(a32 & b32);
      4'd8:  begin alu_r = a32 - b32; alu_err = (alu_a < alu_b); end
      4'd9:  alu_r = ~(a32 | b32);
      4'd10: alu_r = a32 ^ b32;
      4'd11: alu_r = ~(a32 ^ b32);
      4'd12: alu_r = ~a32;
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] op, input logic [15:0] operand);
    in_valid   = 1'b1;
    in_op      = op;
    in_operand = operand;
    @(negedge clk);
    in_valid   = 1'b0;
  endtask

  // Waits for op to appear on the ALU (first EXEC cycle), checks the held
  // inputs for len cycles, then expects done and the new acc.
  task automatic run_one(input string tag, input logic [3:0] op, input int len,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] exp_acc, input bit clr_last);
    int waited = 0;
    while (alu_op_code !== op && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_start"}, 64'(alu_op_code), 64'(op));
    for (int k = 1; k <= len; k++) begin
      check({tag, "_exec"}, 64'({done, alu_op_code, alu_a, alu_b}),
            64'({1'b0, op, a, b}));
      if (k == len && clr_last) clr_flags = 1'b1;
      @(negedge clk);
      clr_flags = 1'b0;
    end
    check({tag, "_done"}, 64'(done), 64'(1));
    check({tag, "_acc"}, 64'(acc), 64'(exp_acc));
  endtask

  initial begin
    int w, pushed, dones, cyc;
    logic [31:0] div_acc;

    // Reset state, with in_valid asserted throughout to show it is ignored.
    in_valid = 1'b1;
    in_op    = 4'd0;
    repeat (2) @(negedge clk);
    check("rst_acc", 64'(acc), 64'(0));
    check("rst_outs", 64'({done, busy, ovf_flag, dz_flag, in_ready, op_count, alu_op_code}),
          64'({1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 4'd13}));
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_busy", 64'(busy), 64'(0));

    // RESET, ADD 6, ADD 6 pushed back-to-back.
    push(4'd3, 16'd0);
    push(4'd0, 16'd6);
    push(4'd0, 16'd6);
    check("reset_done", 64'({done, acc}), 64'({1'b1, 32'd0}));
    run_one("add1", 4'd0, 1, 16'd6, 16'd0, 32'd6, 1'b0);
    run_one("add2", 4'd0, 1, 16'd6, 16'd6, 32'd12, 1'b0);
    check("cnt3", 64'(op_count), 64'(3));

    // MUL holds its inputs for MUL_CYC cycles.
    push(4'd4, 16'd6);
    run_one("mul", 4'd4, MUL_CYC, 16'd6, 16'd12, 32'd72, 1'b0);

    // ADD overflow sets ovf_flag; clr_flags clears it; SUB without borrow.
    push(4'd0, 16'hFFFF);
    run_one("ovf_add", 4'd0, 1, 16'hFFFF, 16'h0048, 32'h0001_0047, 1'b0);
    check("ovf_set", 64'(ovf_flag), 64'(1));
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    check("ovf_clr", 64'(ovf_flag), 64'(0));
    push(4'd8, 16'h0050);
    run_one("sub", 4'd8, 1, 16'h0050, 16'h0047, 32'd9, 1'b0);
    check("ovf_stays0", 64'(ovf_flag), 64'(0));

    // Divide by zero: RESET then DIV 6.
    push(4'd3, 16'd0);
    push(4'd2, 16'd6);
    run_one("reset2", 4'd3, 1, 16'd0, 16'd9, 32'd0, 1'b0);
    run_one("div0", 4'd2, DIV_CYC, 16'd6, 16'd0, 32'hFFFF_FFFF, 1'b0);
    check("dz_set", 64'({dz_flag, ovf_flag}), 64'({1'b1, 1'b0}));
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    check("dz_clr", 64'(dz_flag), 64'(0));
    // Second DIV-by-zero with clr_flags in its retire cycle: set wins.
    push(4'd3, 16'd0);
    push(4'd2, 16'd6);
    run_one("reset3", 4'd3, 1, 16'd0, 16'hFFFF, 32'd0, 1'b0);
    run_one("div0b", 4'd2, DIV_CYC, 16'd6, 16'd0, 32'hFFFF_FFFF, 1'b1);
    check("dz_set_wins", 64'(dz_flag), 64'(1));

    // FIFO back-pressure: 5 pushes during DIV EXEC (0xFFFF / 0xFFFF = 1).
    push(4'd2, 16'hFFFF);
    @(negedge clk);
    check("bp_div_exec", 64'(alu_op_code), 64'(2));
    for (int i = 0; i < 4; i++) begin
      check("bp_ready", 64'(in_ready), 64'(1));
      in_valid   = 1'b1;
      in_op      = 4'd0;
      in_operand = 16'(i + 1);
      @(negedge clk);
    end
    in_operand = 16'd5;
    check("bp_full", 64'(in_ready), 64'(0));
    w = 0;
    div_acc = 32'hX;
    while (!in_ready && w < 50) begin
      if (done) div_acc = acc;
      @(negedge clk);
      w++;
    end
    check("bp_hold_cycles", 64'(w), 64'(DIV_CYC - 3));
    check("bp_div_acc", 64'(div_acc), 64'(1));
    check("bp_first_pop", 64'({alu_op_code, alu_a}), 64'({4'd0, 16'd1}));
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_add1", 64'({done, acc}), 64'({1'b1, 32'd2}));
    run_one("bp_add2", 4'd0, 1, 16'd2, 16'd2, 32'd4, 1'b0);
    run_one("bp_add3", 4'd0, 1, 16'd3, 16'd4, 32'd7, 1'b0);
    run_one("bp_add4", 4'd0, 1, 16'd4, 16'd7, 32'd11, 1'b0);
    run_one("bp_add5", 4'd0, 1, 16'd5, 16'd11, 32'd16, 1'b0);
    check("bp_drained", 64'({busy, in_ready, op_count}), 64'({1'b0, 1'b1, 8'd16}));

    // Reset in cycle 2 of MUL EXEC with two entries queued.
    push(4'd4, 16'd2);
    push(4'd0, 16'd1);
    push(4'd0, 16'd1);
    check("abort_in_mul", 64'({alu_op_code, busy}), 64'({4'd4, 1'b1}));
    rst        = 1'b1;
    in_valid   = 1'b1;
    in_op      = 4'd0;
    in_operand = 16'd7;
    #1;
    check("abort_async", 64'({done, busy, in_ready, op_count, acc}),
          64'({1'b0, 1'b0, 1'b1, 8'd0, 32'd0}));
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("abort_next", 64'({done, busy, in_ready, acc}), 64'({1'b0, 1'b0, 1'b1, 32'd0}));
    dones = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort_no_done", 64'({dones, acc}), 64'({32'd0, 32'd0}));

    // 256 NO-OPs from op_count 0: wraps back to 0, acc untouched.
    pushed = 0;
    dones  = 0;
    cyc    = 0;
    in_op  = 4'd13;
    while ((pushed < 256 || busy) && cyc < 2000) begin
      in_valid = (pushed < 256);
      if (in_valid && in_ready) pushed++;
      @(negedge clk);
      cyc++;
      if (done) dones++;
    end
    in_valid = 1'b0;
    check("noop_dones", 64'(dones), 64'(256));
    check("noop_cycles", 64'(cyc), 64'(513));
    check("noop_state", 64'({op_count, acc}), 64'({8'd0, 32'd0}));

    // PRESET and GROUND override whatever the ALU returns.
    push(4'd15, 16'd0);
    run_one("preset", 4'd15, 1, 16'd0, 16'd0, 32'hFFFF_FFFF, 1'b0);
    push(4'd14, 16'h1234);
    run_one("ground", 4'd14, 1, 16'h1234, 16'hFFFF, 32'd0, 1'b0);
    check("final_count", 64'(op_count), 64'(2));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
